svo_openldi_ser: RTL and testbench

- Parametrised OpenLDI/FPD-Link transmitter core. Packs RGB pixels plus de/vs/hs into 7-bit lane words and serialises them 7:1.
- Supports 18- or 24-bit colour, VESA or JEIDA mapping, and single or dual pixel links.
- Runs on the bit clock, which is 7x the pixel rate, and pulls one beat per 7 cycles from an upstream valid/ready source.
- Feeds LVDS output buffers directly, one serial bit per lane per cycle, plus a generated clock lane per link.

---
 rtl/svo_openldi_ser.sv | 112 +++++++++++
 tb/tb_svo_openldi_ser.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/svo_openldi_ser.sv
// OpenLDI / FPD-Link transmitter core: packs RGB + de/vs/hs into 7-bit lane words
// and shifts them out MSB first on the 7x bit clock, with one clock lane per link.
module svo_openldi_ser #(
    parameter int COLOR_BITS = 6,
    parameter int MAPPING    = 0,
    parameter int PIXELS     = 1,
    localparam int LANES     = (COLOR_BITS == 8) ? 4 : 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_de,
    input  logic                           in_vs,
    input  logic                           in_hs,
    input  logic [PIXELS*3*COLOR_BITS-1:0] in_rgb,
    output logic [PIXELS*LANES-1:0]        lane_out,
    output logic [PIXELS-1:0]              clk_out,
    output logic                           underflow
);

    localparam int NLANE = PIXELS * LANES;
    localparam int NW    = NLANE * 7;
    localparam logic [6:0] CLK_PATTERN = 7'b1100011;

    logic [2:0]       phase;
    logic [2:0]       bit_sel;
    logic [NW-1:0]    word;
    logic [NW-1:0]    word_packed;
    logic [NW-1:0]    word_blank;
    logic [NLANE-1:0] lane_next;
    logic             last_vs;
    logic             last_hs;

    // Components arrive zero-extended to 8 bits; in 6-bit mode only [5:0] matter.
    function automatic logic [6:0] pack_lane(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b, input logic de,
                                             input logic vs, input logic hs, input int lane);
        logic [5:0] r6, g6, b6;
        logic [1:0] rx, gx, bx;
        logic [6:0] lw;
        if (COLOR_BITS == 8 && MAPPING == 1) begin
            r6 = r[7:2]; g6 = g[7:2]; b6 = b[7:2];
            rx = r[1:0]; gx = g[1:0]; bx = b[1:0];
        end else begin
            r6 = r[5:0]; g6 = g[5:0]; b6 = b[5:0];
            rx = r[7:6]; gx = g[7:6]; bx = b[7:6];
        end
        case (lane)
            0:       lw = {g6[0], r6};
            1:       lw = {b6[1:0], g6[5:1]};
            2:       lw = {de, vs, hs, b6[5:2]};
            default: lw = {1'b0, bx, gx, rx};
        endcase
        return lw;
    endfunction

    always_comb begin
        word_packed = '0;
        word_blank  = '0;
        for (int p = 0; p < PIXELS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                word_packed[(p*LANES+l)*7 +: 7] = pack_lane(
                    8'(in_rgb[p*3*COLOR_BITS +: COLOR_BITS]),
                    8'(in_rgb[p*3*COLOR_BITS+COLOR_BITS +: COLOR_BITS]),
                    8'(in_rgb[p*3*COLOR_BITS+2*COLOR_BITS +: COLOR_BITS]),
                    in_de, in_vs, in_hs, l);
                word_blank[(p*LANES+l)*7 +: 7] = pack_lane(
                    8'h00, 8'h00, 8'h00, 1'b0, last_vs, last_hs, l);
            end
        end
    end

    assign in_ready = (phase == 3'd6);
    assign bit_sel  = 3'd6 - phase;

    always_comb begin
        lane_next = '0;
        for (int i = 0; i < NLANE; i++) begin
            lane_next[i] = word[i*7 + int'(bit_sel)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= 3'd0;
            word      <= '0;
            last_vs   <= 1'b0;
            last_hs   <= 1'b0;
            lane_out  <= '0;
            clk_out   <= '0;
            underflow <= 1'b0;
        end else begin
            phase     <= (phase == 3'd6) ? 3'd0 : phase + 3'd1;
            lane_out  <= lane_next;
            clk_out   <= {PIXELS{CLK_PATTERN[bit_sel]}};
            underflow <= 1'b0;
            // Word boundary: take the new beat, or repeat blanking with held syncs.
            if (phase == 3'd6) begin
                if (in_valid) begin
                    word    <= word_packed;
                    last_vs <= in_vs;
                    last_hs <= in_hs;
                end else begin
                    word      <= word_blank;
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_svo_openldi_ser.sv
// Directed bench for svo_openldi_ser: four parameterisations run in lock-step, with
// serial lane words reassembled and compared against hand-packed values.
module tb_svo_openldi_ser;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_de, in_vs, in_hs;
    logic [17:0] rgb6;
    logic [23:0] rgbv, rgbj;
    logic [35:0] rgbd;

    logic [2:0] lo6;
    logic [3:0] lov, loj;
    logic [5:0] lod;
    logic [0:0] clk6, clkv, clkj;
    logic [1:0] clkd;
    logic rdy6, rdyv, rdyj, rdyd;
    logic uf6, ufv, ufj, ufd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] s6 [3];
    logic [6:0] sv [4];
    logic [6:0] sj [4];
    logic [6:0] sd [6];
    logic [6:0] c6, cd0, cd1, rdy_seq, uf_seq;

    always #5 clk = ~clk;

    svo_openldi_ser #(.COLOR_BITS(6), .MAPPING(0), .PIXELS(1)) u_d6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy6), .in_de(in_de),
        .in_vs(in_vs), .in_hs(in_hs), .in_rgb(rgb6), .lane_out(lo6), .clk_out(clk6),
        .underflow(uf6));

    svo_openldi_ser #(.COLOR_BITS(8), .MAPPING(0), .PIXELS(1)) u_dv (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyv), .in_de(in_de),
        .in_vs(in_vs), .in_hs(in_hs), .in_rgb(rgbv), .lane_out(lov), .clk_out(clkv),
        .underflow(ufv));

    svo_openldi_ser #(.COLOR_BITS(8), .MAPPING(1), .PIXELS(1)) u_dj (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyj), .in_de(in_de),
        .in_vs(in_vs), .in_hs(in_hs), .in_rgb(rgbj), .lane_out(loj), .clk_out(clkj),
        .underflow(ufj));

    svo_openldi_ser #(.COLOR_BITS(6), .MAPPING(0), .PIXELS(2)) u_dd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyd), .in_de(in_de),
        .in_vs(in_vs), .in_hs(in_hs), .in_rgb(rgbd), .lane_out(lod), .clk_out(clkd),
        .underflow(ufd));

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture one 7-cycle word starting at phase 0; the next beat is presented
    // during the phase-6 cycle so it is taken on the frame's final edge.
    task automatic frame(input logic nv, input logic nde, input logic nvs, input logic nhs,
                         input logic [17:0] n6, input logic [23:0] n8, input logic [35:0] nd);
        for (int i = 0; i < 7; i++) begin
            rdy_seq = {rdy_seq[5:0], rdy6};
            if (i == 6) begin
                in_valid = nv; in_de = nde; in_vs = nvs; in_hs = nhs;
                rgb6 = n6; rgbv = n8; rgbj = n8; rgbd = nd;
            end
            tick();
            for (int l = 0; l < 3; l++) s6[l] = {s6[l][5:0], lo6[l]};
            for (int l = 0; l < 4; l++) sv[l] = {sv[l][5:0], lov[l]};
            for (int l = 0; l < 4; l++) sj[l] = {sj[l][5:0], loj[l]};
            for (int l = 0; l < 6; l++) sd[l] = {sd[l][5:0], lod[l]};
            c6     = {c6[5:0], clk6[0]};
            cd0    = {cd0[5:0], clkd[0]};
            cd1    = {cd1[5:0], clkd[1]};
            uf_seq = {uf_seq[5:0], uf6};
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_de = 1'b0; in_vs = 1'b0; in_hs = 1'b0;
        rgb6 = '0; rgbv = '0; rgbj = '0; rgbd = '0;
        repeat (3) tick();
        chk_val("rst_lane", 32'(lo6), 32'd0);
        chk_val("rst_clk", 32'(clkd), 32'd0);
        chk_val("rst_ready", 32'(rdy6), 32'd0);
        chk_val("rst_uf", 32'(uf6), 32'd0);
        reset = 1'b0;

        // zero word after reset; B1 = packing vectors
        frame(1'b1, 1'b1, 1'b0, 1'b1, {6'h3F, 6'h15, 6'h2A}, {8'h00, 8'h00, 8'hC5},
              {6'h00, 6'h00, 6'h20, 6'h00, 6'h00, 6'h01});
        chk_val("init_lane0", 32'(s6[0]), 32'd0);
        chk_val("init_lane2", 32'(s6[2]), 32'd0);
        chk_val("init_clk", 32'(c6), 32'b1100011);
        chk_val("init_ready", 32'(rdy_seq), 32'b0000001);
        chk_val("init_uf", 32'(uf_seq), 32'd0);

        // B2: blank-ish beat with vs=1 hs=0
        frame(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        chk_val("pk6_lane0", 32'(s6[0]), 32'b1101010);
        chk_val("pk6_lane1", 32'(s6[1]), 32'b1101010);
        chk_val("pk6_lane2", 32'(s6[2]), 32'b1011111);
        chk_val("pk6_clk", 32'(c6), 32'b1100011);
        chk_val("vesa_lane0", 32'(sv[0]), 32'b0000101);
        chk_val("vesa_lane3", 32'(sv[3]), 32'b0000011);
        chk_val("jeida_lane0", 32'(sj[0]), 32'b0110001);
        chk_val("jeida_lane3", 32'(sj[3]), 32'b0000001);
        chk_val("dual_l0_lane0", 32'(sd[0]), 32'b0000001);
        chk_val("dual_l1_lane0", 32'(sd[3]), 32'b0100000);
        chk_val("dual_l0_lane2", 32'(sd[2]), 32'b1010000);
        chk_val("dual_l1_lane2", 32'(sd[5]), 32'b1010000);
        chk_val("dual_clk0", 32'(cd0), 32'b1100011);
        chk_val("dual_clk1", 32'(cd1), 32'b1100011);

        // no beat offered at the next boundary
        frame(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk_val("b2_lane2", 32'(s6[2]), 32'b0100000);
        chk_val("b2_lane0", 32'(s6[0]), 32'd0);
        chk_val("uf_pulse", 32'(uf_seq), 32'b0000001);
        chk_val("uf_dual", 32'(ufd), 32'd1);

        frame(1'b1, 1'b1, 1'b0, 1'b0, {6'h00, 6'h00, 6'h3F}, '0, '0);
        chk_val("blank_lane2", 32'(s6[2]), 32'b0100000);
        chk_val("blank_lane0", 32'(s6[0]), 32'd0);
        chk_val("blank_lane1", 32'(s6[1]), 32'd0);
        chk_val("uf_cleared", 32'(uf_seq), 32'd0);

        frame(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0);
        chk_val("resume_lane0", 32'(s6[0]), 32'b0111111);
        chk_val("resume_lane2", 32'(s6[2]), 32'b1000000);
        chk_val("resume_uf", 32'(uf_seq), 32'd0);

        // mid-word reset at phase 3 of a word with de/vs/hs all high
        repeat (3) tick();
        chk_val("pre_rst_lane2", 32'(lo6[2]), 32'd1);
        reset = 1'b1;
        #1;
        chk_val("mid_rst_lane", 32'(lo6), 32'd0);
        chk_val("mid_rst_dual", 32'(lod), 32'd0);
        chk_val("mid_rst_ready", 32'(rdy6), 32'd0);
        chk_val("mid_rst_uf", 32'(uf6), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        frame(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk_val("post_rst_lane2", 32'(s6[2]), 32'd0);
        chk_val("post_rst_lane0", 32'(s6[0]), 32'd0);
        chk_val("post_rst_clk", 32'(c6), 32'b1100011);
        chk_val("post_rst_ready", 32'(rdy_seq), 32'b0000001);
        frame(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk_val("post_rst_ready2", 32'(rdy_seq), 32'b0000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
